// File: rtl/uart_rx_ctrl_if.sv
// Byte-level handshake between a UART receiver, the receive controller and its consumer.
// The slave modport is the controller; the master modport drives the receiver/consumer side.
interface uart_rx_ctrl_if;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;

  modport master (
    output rxData, rxDone, rxErr, outReady,
    input  outData, outValid
  );

  modport slave (
    input  rxData, rxDone, rxErr, outReady,
    output outData, outValid
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive controller: buffers receiver bytes in a FIFO and tracks errors and overrun.
// The idle-timeout pulse is built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int Depth         = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    enable,
  uart_rx_ctrl_if.slave           bus,
  input  logic                    clearErr,
  output logic [$clog2(Depth):0]  level,
  output logic                    overrun,
  output logic [7:0]              errCount,
  output logic                    timeout
);

  localparam int AddrW  = $clog2(Depth);
  localparam int LevelW = AddrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT            state;
  logic             pushPend;
  logic [AddrW-1:0] wrPtr;
  logic [AddrW-1:0] rdPtr;
  logic [7:0]       mem [Depth];
  logic             full;
  logic             pop;
  logic             pushReq;
  logic             pushAcc;
  logic             dropByte;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign full         = (level == LevelW'(Depth));
  assign bus.outValid = (level != '0);
  assign bus.outData  = mem[rdPtr];
  assign pop          = bus.outValid && bus.outReady;
  assign pushReq      = pushPend && (state == RUN);
  assign pushAcc      = pushReq && (!full || pop);
  assign dropByte     = pushReq && full && !pop;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)             state <= RUN;
          else if (level == '0)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The receiver presents its byte one cycle after rxDone, so the pulse is delayed once.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pushPend <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
    end else begin
      pushPend <= bus.rxDone;
      if (pushAcc) wrPtr <= wrPtr + AddrW'(1);
      if (pop)     rdPtr <= rdPtr + AddrW'(1);
      if (pushAcc && !pop)      level <= level + LevelW'(1);
      else if (pop && !pushAcc) level <= level - LevelW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pushAcc) mem[wrPtr] <= bus.rxData;
  end

  // A clear loses to an error or drop arriving in the same cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      errCount <= '0;
      overrun  <= 1'b0;
    end else if (clearErr) begin
      errCount <= bus.rxErr ? 8'd1 : 8'd0;
      overrun  <= dropByte;
    end else begin
      if (bus.rxErr && errCount != 8'hFF) errCount <= errCount + 8'd1;
      if (dropByte) overrun <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int CountW = $clog2(TimeoutCycles + 1);

  logic [CountW-1:0] idleCount;
  logic              armed;

  // After one pulse the counter stays quiet until a new byte is accepted.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      idleCount <= '0;
      armed     <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (pushAcc) armed <= 1'b1;
      if (state != RUN || pushAcc || pop || level == '0) begin
        idleCount <= '0;
      end else if (armed) begin
        if (idleCount == CountW'(TimeoutCycles - 1)) begin
          timeout   <= 1'b1;
          armed     <= 1'b0;
          idleCount <= '0;
        end else begin
          idleCount <= idleCount + CountW'(1);
        end
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed byte streams, overflow, error counting, drain and reset.
// Build with UART_RX_CTRL_TIMEOUT_EN defined to exercise the idle-timeout pulse.
module tb_uart_rx_ctrl;

  localparam int Depth         = 8;
  localparam int TimeoutCycles = 16;

  logic                   clk = 1'b0;
  logic                   nReset;
  logic                   enable;
  logic                   clearErr;
  logic [$clog2(Depth):0] level;
  logic                   overrun;
  logic [7:0]             errCount;
  logic                   timeout;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic [7:0] t1Bytes [3] = '{8'h41, 8'h42, 8'h43};
  logic [7:0] b;
  int         pulses;
  int         firstAt;

  uart_rx_ctrl_if dutIf ();

  uart_rx_ctrl #(
    .Depth(Depth),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .enable(enable),
    .bus(dutIf),
    .clearErr(clearErr),
    .level(level),
    .overrun(overrun),
    .errCount(errCount),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rxDone pulse, then the byte one cycle later; optionally the consumer accepts on the capture cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic popOnCapture);
    @(posedge clk); #1;
    dutIf.rxDone = 1'b1;
    @(posedge clk); #1;
    dutIf.rxDone = 1'b0;
    dutIf.rxData = data;
    if (popOnCapture) dutIf.outReady = 1'b1;
    @(posedge clk); #1;
    if (popOnCapture) dutIf.outReady = 1'b0;
  endtask

  task automatic scoreboardMonitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (nReset && dutIf.outValid && dutIf.outReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sbUnexpected: got 0x%0h, expected no output", dutIf.outData);
        end else begin
          exp = sb.pop_front();
          checkOutput("sbData", {24'd0, dutIf.outData}, {24'd0, exp});
        end
      end
    end
  endtask

  task automatic watchdog();
    #200000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  endtask

  initial begin
    nReset         = 1'b0;
    enable         = 1'b0;
    clearErr       = 1'b0;
    dutIf.rxData   = 8'h00;
    dutIf.rxDone   = 1'b0;
    dutIf.rxErr    = 1'b0;
    dutIf.outReady = 1'b0;
    fork
      scoreboardMonitor();
      watchdog();
    join_none
    tick(2);
    nReset = 1'b1;
    tick(1);

    checkOutput("rstLevel", 32'(level), 0);
    checkOutput("rstOutValid", 32'(dutIf.outValid), 0);
    checkOutput("rstOverrun", 32'(overrun), 0);
    checkOutput("rstErrCount", 32'(errCount), 0);
    checkOutput("rstTimeout", 32'(timeout), 0);

    // Three bytes streamed straight through to a ready consumer.
    enable = 1'b1;
    dutIf.outReady = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(t1Bytes[i]);
      applyStimulus(t1Bytes[i], 1'b0);
      checkOutput("capOutValid", 32'(dutIf.outValid), 1);
      checkOutput("capOutData", 32'(dutIf.outData), 32'(t1Bytes[i]));
    end
    tick(2);
    checkOutput("streamLevel", 32'(level), 0);
    checkOutput("streamSbEmpty", 32'(sb.size()), 0);

    // Nine bytes into a stalled FIFO: the ninth is dropped.
    dutIf.outReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h10 + 8'(i);
      if (i < 8) sb.push_back(b);
      applyStimulus(b, 1'b0);
    end
    checkOutput("fullLevel", 32'(level), 8);
    checkOutput("fullOverrun", 32'(overrun), 1);
    checkOutput("fullHead", 32'(dutIf.outData), 32'h10);
    clearErr = 1'b1;
    applyStimulus(8'h1A, 1'b0);
    clearErr = 1'b0;
    checkOutput("clearVsDropOverrun", 32'(overrun), 1);
    checkOutput("clearVsDropLevel", 32'(level), 8);
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    checkOutput("clearOverrun", 32'(overrun), 0);
    dutIf.outReady = 1'b1;
    tick(10);
    dutIf.outReady = 1'b0;
    checkOutput("drainLevel", 32'(level), 0);
    checkOutput("drainSbEmpty", 32'(sb.size()), 0);

    // Full FIFO with a simultaneous pop: the new byte goes to the tail.
    for (int i = 0; i < 8; i++) begin
      b = 8'h20 + 8'(i);
      sb.push_back(b);
      applyStimulus(b, 1'b0);
    end
    checkOutput("refillLevel", 32'(level), 8);
    sb.push_back(8'h28);
    applyStimulus(8'h28, 1'b1);
    checkOutput("pushPopLevel", 32'(level), 8);
    checkOutput("pushPopOverrun", 32'(overrun), 0);
    checkOutput("pushPopHead", 32'(dutIf.outData), 32'h21);
    dutIf.outReady = 1'b1;
    tick(10);
    dutIf.outReady = 1'b0;
    checkOutput("pushPopDrainLevel", 32'(level), 0);
    checkOutput("pushPopSbEmpty", 32'(sb.size()), 0);

    // Error counter saturation and clear-versus-error priority.
    for (int i = 0; i < 10; i++) begin
      dutIf.rxErr = 1'b1;
      tick(1);
      dutIf.rxErr = 1'b0;
      tick(1);
    end
    checkOutput("errCount10", 32'(errCount), 10);
    for (int i = 0; i < 290; i++) begin
      dutIf.rxErr = 1'b1;
      tick(1);
      dutIf.rxErr = 1'b0;
      tick(1);
    end
    checkOutput("errCountSat", 32'(errCount), 255);
    clearErr = 1'b1;
    dutIf.rxErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    dutIf.rxErr = 1'b0;
    checkOutput("clearWithErr", 32'(errCount), 1);
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    checkOutput("clearErrCount", 32'(errCount), 0);

    // Drop enable with three bytes held: drain them, ignore new arrivals.
    for (int i = 0; i < 3; i++) begin
      b = 8'h51 + 8'(i);
      sb.push_back(b);
      applyStimulus(b, 1'b0);
    end
    checkOutput("preDrainLevel", 32'(level), 3);
    enable = 1'b0;
    tick(1);
    checkOutput("drainState", 32'(dut.state), 2);
    applyStimulus(8'h5F, 1'b0);
    checkOutput("drainIgnoreLevel", 32'(level), 3);
    checkOutput("drainIgnoreOverrun", 32'(overrun), 0);
    dutIf.outReady = 1'b1;
    tick(3);
    checkOutput("drainEmptyLevel", 32'(level), 0);
    tick(1);
    dutIf.outReady = 1'b0;
    checkOutput("idleState", 32'(dut.state), 0);
    checkOutput("drainSbEmpty2", 32'(sb.size()), 0);

    // Asynchronous reset in the middle of a stream.
    enable = 1'b1;
    tick(1);
    sb.push_back(8'h61);
    applyStimulus(8'h61, 1'b0);
    sb.push_back(8'h62);
    applyStimulus(8'h62, 1'b0);
    checkOutput("preResetLevel", 32'(level), 2);
    #2;
    nReset = 1'b0;
    sb.delete();
    #1;
    checkOutput("asyncRstLevel", 32'(level), 0);
    checkOutput("asyncRstOutValid", 32'(dutIf.outValid), 0);
    tick(1);
    nReset = 1'b1;
    tick(2);
    sb.push_back(8'h66);
    dutIf.outReady = 1'b1;
    applyStimulus(8'h66, 1'b0);
    tick(2);
    dutIf.outReady = 1'b0;
    checkOutput("postRstSbEmpty", 32'(sb.size()), 0);

    // One byte held with no consumer: watch the idle-timeout output.
    sb.push_back(8'h77);
    applyStimulus(8'h77, 1'b0);
    pulses  = 0;
    firstAt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (timeout) begin
        pulses++;
        if (firstAt == 0) firstAt = i;
      end
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    checkOutput("timeoutPulses", 32'(pulses), 1);
    checkOutput("timeoutDelay", 32'(firstAt), TimeoutCycles);
`else
    checkOutput("timeoutTiedLow", 32'(pulses), 0);
`endif
    dutIf.outReady = 1'b1;
    tick(2);
    dutIf.outReady = 1'b0;
    checkOutput("finalLevel", 32'(level), 0);
    checkOutput("finalSbEmpty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter Depth, default 8, receive FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, idle clocks before a timeout pulse (at least 2).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port nReset, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, receive enable.
REQ-006 SHALL have port rxData, input, 8, byte from receiver.
REQ-007 SHALL have port rxDone, input, 1, one-cycle frame-complete pulse from receiver.
REQ-008 SHALL have port rxErr, input, 1, one-cycle framing/sync error pulse from receiver.
REQ-009 SHALL have port outData, output, 8, FIFO head byte.
REQ-010 SHALL have port outValid, output, 1, outData valid.
REQ-011 SHALL have port outReady, input, 1, consumer accepts.
REQ-012 SHALL have port level, output, clog2(Depth)+1, FIFO occupancy.
REQ-013 SHALL have port overrun, output, 1, sticky byte-dropped flag.
REQ-014 SHALL have port errCount, output, 8, saturating rxErr count.
REQ-015 SHALL have port clearErr, input, 1, clears overrun and errCount.
REQ-016 SHALL have port timeout, output, 1, one-cycle idle-timeout pulse.

Function
REQ-017 SHALL register rxDone into pushPend and capture rxData into the FIFO on the following cycle, because receiver data updates one cycle after rxDone.
REQ-018 SHALL implement states IDLE, RUN and DRAIN.
- IDLE to RUN when enable=1.
- RUN to DRAIN when enable=0.
- DRAIN to RUN when enable=1.
- DRAIN to IDLE when level=0 and enable=0.
REQ-019 SHALL push only in RUN; pushPend in IDLE or DRAIN SHALL be discarded without setting overrun.
REQ-020 SHALL pop when outValid && outReady; outValid = (level != 0); outData = head entry, combinational from FIFO storage.
REQ-021 SHALL accept a push while full if a pop occurs the same cycle; level unchanged.
REQ-022 SHALL, on push while full without pop, drop the byte, keep FIFO contents and set overrun.
REQ-023 SHALL wrap read/write pointers modulo Depth; level = writes - reads, range 0..Depth.
REQ-024 SHALL increment errCount on each rxErr, saturating at 255, in any state.
REQ-025 SHALL, when clearErr=1, zero errCount and overrun; rxErr in the same cycle leaves errCount=1; overflow in the same cycle leaves overrun=1.
REQ-026 SHALL keep outData/outValid stable while outValid && !outReady.

Reset
REQ-027 SHALL on nReset=0 asynchronously set state=IDLE, level=0, pointers=0, pushPend=0, outValid=0, overrun=0, errCount=0, timeout=0, idle counter=0.
REQ-028 SHALL discard FIFO contents on reset mid-operation; outData value is don't-care while outValid=0.

Configuration
REQ-029 SHALL compile the idle-timeout counter only when macro UART_RX_CTRL_TIMEOUT_EN is defined.
REQ-030 SHALL, with the macro, count clocks in RUN while level != 0 and no push occurs, reset the count on push, pop or leaving RUN, pulse timeout one cycle when the count reaches TimeoutCycles, then hold until rearmed by the next push.
REQ-031 SHALL, without the macro, tie timeout to 0 and instantiate no counter.

Verification
REQ-032 SHALL cover: enable=1, three rxDone pulses with rxData 0x41, 0x42, 0x43, outReady=1 -> outData 0x41, 0x42, 0x43 in order, each one cycle after capture, level returns to 0.
REQ-033 SHALL cover: Depth=8, outReady=0, nine bytes -> level=8, overrun=1, ninth byte lost; then drain yields the first eight bytes.
REQ-034 SHALL cover: full FIFO, push and pop the same cycle -> level stays 8, new byte appears last.
REQ-035 SHALL cover: 300 rxErr pulses -> errCount=255; clearErr with a simultaneous rxErr -> errCount=1.
REQ-036 SHALL cover: enable dropped with level=3 -> DRAIN, new rxDone ignored, IDLE after third pop; nReset mid-stream -> level=0, outValid=0 immediately.
REQ-037 SHALL cover, with UART_RX_CTRL_TIMEOUT_EN defined: one byte held, outReady=0, TimeoutCycles=16 -> single timeout pulse 16 clocks after push, none thereafter.
